serial_collector: RTL

SERIAL_COLLECTOR -- requirements
Module: serial_collector

---
 rtl/serial_collector.sv | 133 +++++++++++++
 1 files changed

// File: rtl/serial_collector.sv
// serial_collector
//   Collects a qualified serial bit stream into WIDTH-bit words (first bit
//   received ends up in the MSB) and hands each completed word to a consumer
//   through a valid/ready handshake. It also flags words equal to PATTERN and
//   remembers whether a bit was ever dropped because a word was still pending.
//
// Ports
//   clk        : single clock, all state changes on the rising edge
//   clear      : synchronous active-low reset
//   d          : serial data bit
//   d_en       : qualifies d; a bit is only taken when d_en=1
//   word       : last completed word (WIDTH bits)
//   word_valid : word holds a completed word not yet consumed
//   word_ready : consumer accepts word (only meaningful while word_valid=1)
//   match      : one-cycle pulse when a newly completed word equals PATTERN
//   overrun    : sticky, set when a qualified bit arrives while a word waits
//   count      : bits gathered toward the next word, 0..WIDTH-1
module serial_collector #(
  parameter int                 WIDTH   = 4,
  parameter logic [WIDTH-1:0]   PATTERN = 4'b1011
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             d,
  input  logic             d_en,
  output logic [WIDTH-1:0] word,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             match,
  output logic             overrun,
  output logic [2:0]       count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [2:0] LAST_COUNT = 3'(WIDTH - 1);

  state_t             state_reg;
  // Only the WIDTH-1 most recent bits are kept: the completing bit is taken
  // straight from d, so the oldest stored bit would never be read again.
  logic [WIDTH-2:0]   shreg_reg;
  logic [WIDTH-1:0]   word_reg;
  logic               word_valid_reg;
  logic               match_reg;
  logic               overrun_reg;
  logic [2:0]         count_reg;

  // Shift-left-and-insert view of the register with d as the new LSB.
  // When the last bit of a word arrives this is exactly the completed word.
  logic [WIDTH-1:0]   shifted;

  assign shifted[0] = d;

  genvar gi;
  generate
    for (gi = 1; gi < WIDTH; gi++) begin : g_shift
      assign shifted[gi] = shreg_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!clear) begin
      state_reg      <= IDLE;
      shreg_reg      <= '0;
      word_reg       <= '0;
      word_valid_reg <= 1'b0;
      match_reg      <= 1'b0;
      overrun_reg    <= 1'b0;
      count_reg      <= 3'd0;
    end else begin
      // match is a pulse; it is only raised on the completing edge below.
      match_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (d_en) begin
            shreg_reg <= shifted[WIDTH-2:0];
            count_reg <= 3'd1;
            state_reg <= FILL;
          end
        end

        FILL: begin
          if (d_en) begin
            shreg_reg <= shifted[WIDTH-2:0];
            if (count_reg == LAST_COUNT) begin
              word_reg       <= shifted;
              word_valid_reg <= 1'b1;
              match_reg      <= (shifted == PATTERN);
              count_reg      <= 3'd0;
              state_reg      <= HOLD;
            end else begin
              count_reg <= count_reg + 3'd1;
            end
          end
        end

        HOLD: begin
          if (word_ready) begin
            // Handshake; word itself keeps its value after being consumed.
            word_valid_reg <= 1'b0;
            if (d_en) begin
              // The same edge also takes the first bit of the next word.
              shreg_reg <= shifted[WIDTH-2:0];
              count_reg <= 3'd1;
              state_reg <= FILL;
            end else begin
              state_reg <= IDLE;
            end
          end else if (d_en) begin
            // Nowhere to put the bit while the word waits: drop it.
            overrun_reg <= 1'b1;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign word       = word_reg;
  assign word_valid = word_valid_reg;
  assign match      = match_reg;
  assign overrun    = overrun_reg;
  assign count      = count_reg;

endmodule
